// File: rtl/ramdisk_arbiter.sv
// Three-way arbiter sharing one byte-wide SDRAM port between video fetch,
// the CPU (through the RAM-disk mapper) and the host loader.
module ramdisk_arbiter #(
    parameter int LD_STARVE = 4,
    parameter int TIMEOUT   = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        vid_req,
    input  logic [15:0] vid_addr,
    output logic        vid_ack,
    output logic [7:0]  vid_dout,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [2:0]  cpu_page,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic        cpu_ack,
    output logic [7:0]  cpu_dout,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [2:0]  ld_page,
    input  logic [15:0] ld_addr,
    input  logic [7:0]  ld_din,
    output logic        ld_ack,
    output logic [7:0]  ld_dout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [18:0] mem_addr,
    output logic [7:0]  mem_din,
    input  logic        mem_ack,
    input  logic [7:0]  mem_dout,
    output logic [1:0]  grant,
    output logic        err
);
    localparam int SW = $clog2(LD_STARVE + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(LD_STARVE);
    localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT - 1);

    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_VID  = 2'd1;
    localparam logic [1:0] G_CPU  = 2'd2;
    localparam logic [1:0] G_LD   = 2'd3;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state_q, state_d;
    logic [1:0]    grant_q, grant_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [18:0]   mem_addr_q, mem_addr_d;
    logic [7:0]    mem_din_q, mem_din_d;
    logic [7:0]    vid_dout_q, vid_dout_d;
    logic [7:0]    cpu_dout_q, cpu_dout_d;
    logic [7:0]    ld_dout_q, ld_dout_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
    logic [1:0]    winner;
    logic          resp_valid;
    logic [7:0]    resp_data;

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        mem_req_d  = mem_req_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        starve_d   = starve_q;
        timer_d    = timer_q;
        err_d      = err_q;
        winner     = G_NONE;
        resp_valid = 1'b0;
        resp_data  = 8'h00;

        unique case (state_q)
            IDLE: begin
                if (vid_req || cpu_req || ld_req) begin
                    // A starved loader jumps the CPU but never video.
                    if (vid_req)
                        winner = G_VID;
                    else if (ld_req && starve_q == STARVE_MAX)
                        winner = G_LD;
                    else if (cpu_req)
                        winner = G_CPU;
                    else
                        winner = G_LD;

                    case (winner)
                        G_VID: begin
                            mem_we_d   = 1'b0;
                            mem_addr_d = {3'b000, vid_addr};
                            mem_din_d  = 8'h00;
                        end
                        G_CPU: begin
                            mem_we_d   = cpu_we;
                            mem_addr_d = {cpu_page, cpu_addr};
                            mem_din_d  = cpu_din;
                        end
                        default: begin
                            mem_we_d   = ld_we;
                            mem_addr_d = {ld_page, ld_addr};
                            mem_din_d  = ld_din;
                        end
                    endcase

                    if (winner == G_LD)
                        starve_d = '0;
                    else if (ld_req && starve_q != STARVE_MAX)
                        starve_d = starve_q + SW'(1);

                    grant_d   = winner;
                    mem_req_d = 1'b1;
                    timer_d   = '0;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    resp_valid = 1'b1;
                    resp_data  = mem_dout;
                end else if (timer_q == TIMER_MAX) begin
                    resp_valid = 1'b1;
                    resp_data  = 8'hFF;
                    err_d      = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
                if (resp_valid) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    mem_din_d = 8'h00;
                    state_d   = DONE;
                end
            end
            DONE: begin
                grant_d = G_NONE;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Only the owner's read-data register captures the response.
    always_comb begin
        vid_dout_d = vid_dout_q;
        cpu_dout_d = cpu_dout_q;
        ld_dout_d  = ld_dout_q;
        if (resp_valid) begin
            case (grant_q)
                G_VID:   vid_dout_d = resp_data;
                G_CPU:   cpu_dout_d = resp_data;
                G_LD:    ld_dout_d  = resp_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            grant_q    <= G_NONE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            vid_dout_q <= '0;
            cpu_dout_q <= '0;
            ld_dout_q  <= '0;
            starve_q   <= '0;
            timer_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            mem_req_q  <= mem_req_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
            vid_dout_q <= vid_dout_d;
            cpu_dout_q <= cpu_dout_d;
            ld_dout_q  <= ld_dout_d;
            starve_q   <= starve_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
        end
    end

    assign vid_ack  = (state_q == DONE) && (grant_q == G_VID);
    assign cpu_ack  = (state_q == DONE) && (grant_q == G_CPU);
    assign ld_ack   = (state_q == DONE) && (grant_q == G_LD);
    assign vid_dout = vid_dout_q;
    assign cpu_dout = cpu_dout_q;
    assign ld_dout  = ld_dout_q;
    assign mem_req  = mem_req_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
    assign grant    = grant_q;
    assign err      = err_q;
endmodule
